// File: rtl/fd_scan_controller.sv
// rtl/fd_scan_controller.sv - FAST9 scan sequencer: walks interior pixels, drives fetches, streams corners
module fd_scan_controller #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int BORDER = 3,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] refAddr,
    output logic [4:0]        adjNumber,
    output logic [4:0]        regAddr,
    output logic              readen,
    input  logic              isCorner,
    output logic              cornerValid,
    output logic [ADDR_W-1:0] cornerAddr,
    input  logic              cornerReady,
    output logic [15:0]       cornerCount
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0]     COL_FIRST  = CW'(BORDER);
    localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 1 - BORDER);
    localparam logic [RW-1:0]     ROW_FIRST  = RW'(BORDER);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1 - BORDER);
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BORDER * IMG_W + BORDER);
    // Jump from the last interior column of one row to the first of the next.
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(2 * BORDER + 1);
    localparam logic [4:0]        ADJ_LAST   = 5'd16;

    generate
        if (IMG_W <= 2 * BORDER || IMG_H <= 2 * BORDER) begin : g_bad_geometry
            $error("fd_scan_controller: image must be larger than twice BORDER in both dimensions");
        end
        if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_addr_w
            $error("fd_scan_controller: ADDR_W too small for IMG_W*IMG_H");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        EVAL,
        EMIT,
        NEXT,
        FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            refAddr     <= '0;
            adjNumber   <= '0;
            regAddr     <= '0;
            readen      <= 1'b0;
            cornerValid <= 1'b0;
            cornerAddr  <= '0;
            cornerCount <= '0;
        end else begin
            // Register-file write side trails the fetch side by the SRAM read latency.
            readen  <= (state == FETCH);
            regAddr <= adjNumber;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        row         <= ROW_FIRST;
                        col         <= COL_FIRST;
                        refAddr     <= ADDR_FIRST;
                        adjNumber   <= '0;
                        cornerCount <= '0;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end

                FETCH: begin
                    if (adjNumber == ADJ_LAST) begin
                        adjNumber <= '0;
                        state     <= DRAIN;
                    end else begin
                        adjNumber <= adjNumber + 5'd1;
                    end
                end

                DRAIN: state <= EVAL;

                EVAL: begin
                    if (isCorner) begin
                        cornerValid <= 1'b1;
                        cornerAddr  <= refAddr;
                        state       <= EMIT;
                    end else begin
                        state <= NEXT;
                    end
                end

                EMIT: begin
                    if (cornerReady) begin
                        cornerValid <= 1'b0;
                        if (cornerCount != 16'hFFFF) begin
                            cornerCount <= cornerCount + 16'd1;
                        end
                        state <= NEXT;
                    end
                end

                NEXT: begin
                    if (row == ROW_LAST && col == COL_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (col == COL_LAST) begin
                        col     <= COL_FIRST;
                        row     <= row + RW'(1);
                        refAddr <= refAddr + ROW_STEP;
                        state   <= FETCH;
                    end else begin
                        col     <= col + CW'(1);
                        refAddr <= refAddr + ADDR_W'(1);
                        state   <= FETCH;
                    end
                end

                FIN: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fd_scan_controller.sv
// tb/tb_fd_scan_controller.sv - directed scoreboard bench for fd_scan_controller on an 8x8 image
module tb_fd_scan_controller;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int BORDER = 3;
    localparam int ADDR_W = 15;

    logic              clock = 1'b0;
    logic              nReset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] refAddr;
    logic [4:0]        adjNumber;
    logic [4:0]        regAddr;
    logic              readen;
    logic              isCorner;
    logic              cornerValid;
    logic [ADDR_W-1:0] cornerAddr;
    logic              cornerReady;
    logic [15:0]       cornerCount;

    int tests = 0;
    int fails = 0;

    int ref_q[$];
    int corner_q[$];

    fd_scan_controller #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .BORDER(BORDER),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock      (clock),
        .nReset     (nReset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .refAddr    (refAddr),
        .adjNumber  (adjNumber),
        .regAddr    (regAddr),
        .readen     (readen),
        .isCorner   (isCorner),
        .cornerValid(cornerValid),
        .cornerAddr (cornerAddr),
        .cornerReady(cornerReady),
        .cornerCount(cornerCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_expected(input bit corners);
        int pix[4] = '{27, 28, 35, 36};
        foreach (pix[i]) begin
            ref_q.push_back(pix[i]);
            if (corners) corner_q.push_back(pix[i]);
        end
    endtask

    // Runs one full scan; cyc counts edges after the one that accepts start.
    task automatic run_scan(input bit corners, input int stall, input bit restart,
                            input int exp_len, input int exp_count);
        int cyc;
        int vcnt;
        int held;
        bit seen_done;
        push_expected(corners);
        isCorner    = corners;
        cornerReady = (stall == 0);
        start       = 1'b1;
        tick();
        start     = 1'b0;
        cyc       = 0;
        vcnt      = 0;
        held      = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            if (cyc <= 18) begin
                check("adjNumber", 32'(adjNumber), (cyc <= 16) ? 32'(cyc) : 32'd0);
                check("readen", 32'(readen), (cyc >= 1 && cyc <= 17) ? 32'd1 : 32'd0);
                if (readen) check("regAddr", 32'(regAddr), 32'(cyc - 1));
            end
            if (readen && regAddr == 5'd0) begin
                if (ref_q.size() == 0) check("ref_q_underflow", 32'd1, 32'd0);
                else check("refAddr", 32'(refAddr), 32'(ref_q.pop_front()));
            end
            if (cornerValid) begin
                if (vcnt == 0) begin
                    if (corner_q.size() == 0) begin
                        check("corner_q_underflow", 32'd1, 32'd0);
                        held = -1;
                    end else begin
                        held = corner_q.pop_front();
                        check("cornerAddr", 32'(cornerAddr), 32'(held));
                    end
                end else begin
                    check("cornerAddr_stable", 32'(cornerAddr), 32'(held));
                end
                if (vcnt == stall) cornerReady = 1'b1;
                vcnt++;
            end else begin
                vcnt        = 0;
                cornerReady = (stall == 0);
            end
            if (restart) start = (cyc == 30);
            if (done) begin
                seen_done = 1'b1;
                check("done_latency", 32'(cyc), 32'(exp_len));
                check("busy_at_done", 32'(busy), 32'd0);
                check("cornerCount", 32'(cornerCount), 32'(exp_count));
            end else begin
                check("busy_during_scan", 32'(busy), 32'd1);
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("single_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("count_hold", 32'(cornerCount), 32'(exp_count));
        end
        check("ref_q_empty", 32'(ref_q.size()), 32'd0);
        check("corner_q_empty", 32'(corner_q.size()), 32'd0);
    endtask

    initial begin
        nReset      = 1'b0;
        start       = 1'b0;
        isCorner    = 1'b0;
        cornerReady = 1'b0;
        repeat (3) tick();
        nReset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_readen", 32'(readen), 32'd0);
            check("idle_valid", 32'(cornerValid), 32'd0);
            check("idle_count", 32'(cornerCount), 32'd0);
        end

        run_scan(1'b0, 0, 1'b0, 80, 0);
        run_scan(1'b1, 5, 1'b0, 104, 4);

        // Reset during the second pixel's fetch.
        isCorner    = 1'b1;
        cornerReady = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (21) tick();
        check("mid_refAddr", 32'(refAddr), 32'd28);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_refAddr", 32'(refAddr), 32'd0);
        check("rst_adj", 32'(adjNumber), 32'd0);
        check("rst_regAddr", 32'(regAddr), 32'd0);
        check("rst_readen", 32'(readen), 32'd0);
        check("rst_valid", 32'(cornerValid), 32'd0);
        check("rst_cornerAddr", 32'(cornerAddr), 32'd0);
        check("rst_count", 32'(cornerCount), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("rst_no_done", 32'(done), 32'd0);
        end

        run_scan(1'b1, 0, 1'b1, 84, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fd_scan_controller.md
Name: fd_scan_controller

Overview:
Sequences the FAST9 corner-detection datapath across a whole image stored in SRAM. It walks the reference address over every pixel that is at least BORDER pixels from each edge. For each pixel it drives the 17 SRAM fetches (reference plus 16 circle points) into the pixel register file, samples the corner decision, and emits corner addresses over a valid/ready stream. It replaces free-running sequencing with a start/done-controlled, backpressure-aware scan.

Parameters:
IMG_W, 160, image width in pixels
IMG_H, 120, image height in pixels
BORDER, 3, excluded margin on every side (radius of the FAST circle)
ADDR_W, 15, SRAM/pixel address width; IMG_W*IMG_H must be at most 2^ADDR_W

Ports:
clock  in  1  system clock, rising edge
nReset  in  1  synchronous active-low reset
start  in  1  begin a scan; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the scan completes
refAddr  out  ADDR_W  current reference pixel address (row*IMG_W+col)
adjNumber  out  5  fetch index to address calculator; 0=reference, 1..16=circle points
regAddr  out  5  register-file write index; adjNumber delayed by 1 cycle
readen  out  1  register-file write enable, aligned with the SRAM q (1-cycle read latency)
isCorner  in  1  datapath corner decision, combinational from the register file
cornerValid  out  1  corner address available
cornerAddr  out  ADDR_W  address of detected corner
cornerReady  in  1  downstream accepts cornerAddr when cornerValid && cornerReady
cornerCount  out  16  corners emitted this scan; saturates at 16'hFFFF

Behaviour:
- Reset is synchronous active-low on nReset. Every output resets to 0 and the state returns to IDLE. An in-flight scan is abandoned with no done pulse.
- Row and column counters cover BORDER..IMG_H-1-BORDER and BORDER..IMG_W-1-BORDER, column fastest. refAddr is the registered value row*IMG_W+col, held stable for the whole per-pixel sequence.
- IDLE: when start=1, load row=col=BORDER, clear cornerCount, go to FETCH. busy rises the next cycle.
- FETCH, 17 cycles: adjNumber counts 0..16, one step per cycle.
- Write pipeline: readen and regAddr are the 1-cycle-delayed copies of "in FETCH" and adjNumber. readen is therefore high for exactly 17 consecutive cycles per pixel.
- DRAIN, 1 cycle: covers the final register write (regAddr=16, readen=1). adjNumber holds 0.
- EVAL, 1 cycle: sample isCorner.
  - isCorner=1: go to EMIT.
  - isCorner=0: go to NEXT.
- EMIT: cornerValid=1 and cornerAddr=refAddr, both held stable until cornerReady=1. On the handshake cycle, increment cornerCount (saturating) and go to NEXT. If cornerReady is already 1 on entry, EMIT lasts exactly 1 cycle.
- NEXT, 1 cycle: advance the counters.
  - Column wraps from IMG_W-1-BORDER to BORDER and row increments.
  - After the last pixel (row=IMG_H-1-BORDER, col=IMG_W-1-BORDER), go to FIN.
  - Otherwise go to FETCH.
- FIN: done=1 for one cycle, busy=0 from the same cycle, go to IDLE. cornerCount holds its value until the next start.
- Cycles per pixel: 20 without a corner; 21+stall with a corner (17 FETCH + 1 DRAIN + 1 EVAL + [EMIT] + 1 NEXT).
- start while busy is ignored.
- Degenerate geometry (IMG_W or IMG_H at most 2*BORDER) is illegal. Elaboration must fail via a generate-time check.
- Address arithmetic: refAddr is updated incrementally (+1 per column, +2*BORDER+1 on row wrap). No multiplier.
- isCorner is ignored outside EVAL.

Test Plan:
- Reset/idle: hold nReset=0 for 3 cycles, then release with start=0 for 10 cycles -> busy, done, readen and cornerValid stay 0, and cornerCount=0.
- Fetch timing: IMG_W=IMG_H=8, start pulse -> first refAddr=27. adjNumber runs 0..16 over 17 cycles, readen=1 on the following 17 cycles, and regAddr equals adjNumber delayed by 1.
- No corners: IMG_W=IMG_H=8, isCorner tied 0 -> refAddr visits 27, 28, 35, 36 in order. done pulses once, 80 cycles after start is accepted. cornerCount=0.
- All corners with backpressure: isCorner=1; cornerReady=0 for 5 cycles per EMIT, then 1 -> cornerAddr sequence 27, 28, 35, 36, each held stable while stalled. cornerCount=4. done arrives 4*(21+5)=104 cycles after start.
- Mid-scan reset: assert nReset=0 during the second pixel's FETCH -> all outputs are 0 next cycle, no done pulse. A new start restarts at refAddr=27.
- start ignored while busy: pulse start again during a scan -> scan length and corner sequence are unchanged, and exactly one done pulse occurs.
